// File: rtl/alu_pipe_if.sv
// Handshake/bus bundle for alu_pipe.
// master: operation source and result consumer (upstream/writeback side).
// slave : the ALU itself.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Op1;
  logic [WIDTH-1:0] Op2;
  logic [2:0]       AluOp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Resultado;
  logic             Zero;
  logic             Carry;
  logic             Overflow;
  logic             OpError;

  modport master (
    output in_valid, Op1, Op2, AluOp, out_ready,
    input  in_ready, out_valid, Resultado, Zero, Carry, Overflow, OpError
  );

  modport slave (
    input  in_valid, Op1, Op2, AluOp, out_ready,
    output in_ready, out_valid, Resultado, Zero, Carry, Overflow, OpError
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with valid/ready on both sides and one held result.
// Opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MUL (optional).
// Define ALU_MUL_EN to build the shift-add multiplier (opcode 011, WIDTH cycles);
// without it, 011 is reported as an unsupported opcode.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | no result held, ready for a new operation
// BUSY    | multiply iterating, one multiplier bit per cycle
// HOLD    | result and flags held, out_valid asserted
module alu_pipe #(
  parameter int WIDTH      = 32,
  parameter bit SLT_SIGNED = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1
`ifdef ALU_MUL_EN
    , ST_BUSY = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_e;
  logic [WIDTH:0]   sum_w, diff_w;
  logic             lt;

`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam int         CNT_W  = $clog2(WIDTH);

  // prod holds {partial sum, unconsumed multiplier bits}; it shifts right each step.
  logic [2*WIDTH-1:0] prod_q, prod_d, mul_next;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;

  // One shift-add step: conditionally add multiplicand into the upper half, then shift.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  end
`endif

  assign bus.in_ready  = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & bus.out_ready));
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.Resultado = res_q;
  assign bus.Zero      = zero_q;
  assign bus.Carry     = carry_q;
  assign bus.Overflow  = ovf_q;
  assign bus.OpError   = err_q;

  // Single-cycle datapath evaluated on the live operands; only latched on accept.
  always_comb begin
    sum_w  = {1'b0, bus.Op1} + {1'b0, bus.Op2};
    diff_w = {1'b0, bus.Op1} - {1'b0, bus.Op2};
    if (SLT_SIGNED) lt = $signed(bus.Op1) < $signed(bus.Op2);
    else            lt = bus.Op1 < bus.Op2;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_e   = 1'b0;
    case (bus.AluOp)
      OP_AND: alu_res = bus.Op1 & bus.Op2;
      OP_OR:  alu_res = bus.Op1 | bus.Op2;
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (bus.Op1[WIDTH-1] == bus.Op2[WIDTH-1]) & (sum_w[WIDTH-1] != bus.Op1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];
        alu_v   = (bus.Op1[WIDTH-1] != bus.Op2[WIDTH-1]) & (diff_w[WIDTH-1] != bus.Op1[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, lt};
      default: alu_e = 1'b1;
    endcase
  end

  // FSM next state and result/flag updates.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
`ifdef ALU_MUL_EN
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if ((state_q == ST_HOLD) && bus.out_ready) state_d = ST_IDLE;
        if (accept) begin
          state_d = ST_HOLD;
          res_d   = alu_res;
          zero_d  = (alu_res == '0);
          carry_d = alu_c;
          ovf_d   = alu_v;
          err_d   = alu_e;
`ifdef ALU_MUL_EN
          if (bus.AluOp == OP_MUL) begin
            state_d = ST_BUSY;
            prod_d  = {{WIDTH{1'b0}}, bus.Op2};
            mcand_d = bus.Op1;
            cnt_d   = CNT_W'(WIDTH - 1);
          end
`endif
        end
      end
`ifdef ALU_MUL_EN
      ST_BUSY: begin
        prod_d = mul_next;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          res_d   = mul_next[WIDTH-1:0];
          zero_d  = (mul_next[WIDTH-1:0] == '0);
          carry_d = |mul_next[2*WIDTH-1:WIDTH];
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any held or in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_MUL_EN
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
`ifdef ALU_MUL_EN
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: the driver pushes expected results on accept,
// a monitor pops and compares on every presented result. Honours ALU_MUL_EN.
module tb_alu_pipe;
  parameter int WIDTH      = 32;
  parameter bit SLT_SIGNED = 1'b0;
  localparam int W   = WIDTH;
  localparam int TMO = 2000;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic         z, c, v, e;
    int           due;
  } exp_t;

  logic   clk, rst_n;
  int     cyc;
  int     checks, failures;
  exp_t   sb_q[$];
  bit     front_seen;
  int     rdy_mode;  // 0: out_ready high, 1: low, 2: random

  alu_pipe_if #(.WIDTH(W)) bus ();
  alu_pipe #(.WIDTH(W), .SLT_SIGNED(SLT_SIGNED)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial begin cyc = 0; forever begin @(posedge clk); cyc++; end end

  // Reference: plain integer arithmetic modulo 2^W.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t m;
    logic [63:0] ua, ub, modv, full;
    longint sa, sb, smax, smin, r;
    ua = 64'(a); ub = 64'(b); modv = 64'd1 << W;
    sa = a[W-1] ? longint'(ua - modv) : longint'(ua);
    sb = b[W-1] ? longint'(ub - modv) : longint'(ub);
    smax = longint'(modv >> 1) - 1;
    smin = -longint'(modv >> 1);
    m.res = '0; m.c = 1'b0; m.v = 1'b0; m.e = 1'b0; m.due = 0;
    case (op)
      3'b000: m.res = a & b;
      3'b001: m.res = a | b;
      3'b010: begin
        full = ua + ub; m.res = full[W-1:0]; m.c = (full >= modv);
        r = sa + sb; m.v = (r > smax) || (r < smin);
      end
      3'b110: begin
        full = (ua + modv - ub) % modv; m.res = full[W-1:0]; m.c = (ua < ub);
        r = sa - sb; m.v = (r > smax) || (r < smin);
      end
      3'b111: m.res = (SLT_SIGNED ? (sa < sb) : (ua < ub)) ? W'(1) : '0;
      3'b011: begin
        if (MUL_EN) begin full = ua * ub; m.res = full[W-1:0]; m.c = ((full / modv) != 0); end
        else m.e = 1'b1;
      end
      default: m.e = 1'b1;
    endcase
    m.z = (m.res == '0);
    return m;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic v, input logic e);
    exp_t m;
    m.res = r; m.z = (r == '0); m.c = c; m.v = v; m.e = e; m.due = 0;
    return m;
  endfunction

  function automatic logic [W-1:0] rnd_opnd();
    logic [W-1:0] x;
    case ($urandom_range(0, 5))
      0: x = '0;
      1: x = '1;
      2: x = {1'b1, {(W-1){1'b0}}};
      3: x = {1'b0, {(W-1){1'b1}}};
      4: x = W'($urandom_range(0, 15));
      default: x = W'($urandom);
    endcase
    return x;
  endfunction

  // Present one operation, wait (bounded) for acceptance, record the expectation.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit use_ovr, input exp_t ovr, output int stalls);
    exp_t e;
    bus.in_valid = 1'b1; bus.AluOp = op; bus.Op1 = a; bus.Op2 = b;
    stalls = 0;
    @(negedge clk);
    while (!bus.in_ready && stalls < TMO) begin stalls++; @(negedge clk); end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout op=%b waited=%0d cycles, required acceptance", op, stalls);
    end else begin
      e = use_ovr ? ovr : model(op, a, b);
      e.due = cyc + (((op == 3'b011) && MUL_EN) ? W + 1 : 1);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.Op1 = W'($urandom); bus.Op2 = W'($urandom); bus.AluOp = 3'($urandom);
  endtask

  task automatic go(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int st; exp_t dummy;
    dummy = mk('0, 1'b0, 1'b0, 1'b0);
    issue(op, a, b, 1'b0, dummy, st);
  endtask

  task automatic go_exp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t ex);
    int st;
    issue(op, a, b, 1'b1, ex, st);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < TMO) begin @(negedge clk); t++; end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d after %0d cycles, required 0", sb_q.size(), t);
    end
    @(posedge clk); #1;
  endtask

  // out_ready driver (sole writer of out_ready).
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare every presented result against the queue head; pop on transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out got res=%h with no result outstanding", bus.Resultado);
        end else begin
          e = sb_q[0];
          if (bus.Resultado !== e.res || bus.Zero !== e.z || bus.Carry !== e.c ||
              bus.Overflow !== e.v || bus.OpError !== e.e) begin
            failures++;
            $display("FAIL result got res=%h z%b c%b v%b e%b, expected res=%h z%b c%b v%b e%b",
                     bus.Resultado, bus.Zero, bus.Carry, bus.Overflow, bus.OpError,
                     e.res, e.z, e.c, e.v, e.e);
          end
          if (!front_seen) begin
            front_seen = 1'b1;
            checks++;
            if (cyc != e.due) begin
              failures++;
              $display("FAIL latency first valid at cycle %0d, expected cycle %0d", cyc, e.due);
            end
          end
          if (bus.out_ready) begin
            e = sb_q.pop_front();
            front_seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [W-1:0] ones, tmp, half;
    int st, tot, k;
    checks = 0; failures = 0; front_seen = 1'b0; rdy_mode = 0;
    ones = '1;

    // Reset held 3 cycles with a valid operation offered.
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.AluOp = 3'b010; bus.Op1 = W'(7); bus.Op2 = W'(9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.Zero, bus.Carry, bus.Overflow, bus.OpError} !== 6'b0 ||
          bus.Resultado !== '0) begin
        failures++;
        $display("FAIL reset_state vld=%b rdy=%b res=%h z%b c%b v%b e%b, required all 0",
                 bus.out_valid, bus.in_ready, bus.Resultado, bus.Zero, bus.Carry, bus.Overflow, bus.OpError);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;

    // Directed corner cases.
    go_exp(3'b010, ones, W'(1), mk('0, 1'b1, 1'b0, 1'b0));
    go_exp(3'b010, {1'b0, {(W-1){1'b1}}}, W'(1), mk({1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1, 1'b0));
    tmp = '1; tmp[0] = 1'b0;
    go_exp(3'b110, W'(3), W'(5), mk(tmp, 1'b1, 1'b0, 1'b0));
    go_exp(3'b111, ones, W'(1), mk(SLT_SIGNED ? W'(1) : '0, 1'b0, 1'b0, 1'b0));
    go_exp(3'b100, W'(5), W'(5), mk('0, 1'b0, 1'b0, 1'b1));
    go(3'b101, W'($urandom), W'($urandom));
    go(3'b001, W'($urandom), W'($urandom));
`ifdef ALU_MUL_EN
    go_exp(3'b011, W'(12), W'(11), mk(W'(132), 1'b0, 1'b0, 1'b0));
    half = {1'b1, {(W-1){1'b0}}};
    go_exp(3'b011, half, W'(2), mk('0, 1'b1, 1'b0, 1'b0));
    go(3'b011, W'(16), W'(16));
`else
    half = '0;
    go_exp(3'b011, W'(7), W'(9), mk(half, 1'b0, 1'b0, 1'b1));
`endif
    wait_drain();

    // Throughput: back-to-back ANDs with out_ready high must never stall.
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      issue(3'b000, W'($urandom), W'($urandom), 1'b0, mk('0, 1'b0, 1'b0, 1'b0), st);
      tot += st;
    end
    checks++;
    if (tot != 0) begin
      failures++;
      $display("FAIL throughput stalls=%0d, required 0", tot);
    end
    wait_drain();

    // Backpressure: out_ready low for 3 cycles in the middle of 4 ANDs.
    fork
      for (int i = 0; i < 4; i++) go(3'b000, W'($urandom), W'($urandom));
      begin
        repeat (2) @(posedge clk);
        @(negedge clk); rdy_mode = 1;
        repeat (3) @(negedge clk);
        rdy_mode = 0;
      end
    join
    wait_drain();

`ifdef ALU_MUL_EN
    // Reset pulse while multiplying: the result must never appear.
    go(3'b011, W'($urandom), W'($urandom));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    sb_q.delete(); front_seen = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL busy_reset out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
      end
    end
    @(posedge clk); #1;
`endif

    // Randomized traffic with random backpressure and idle gaps.
    rdy_mode = 2;
    for (int n = 0; n < 300; n++) begin
      go(3'($urandom), rnd_opnd(), rnd_opnd());
      k = $urandom_range(0, 2);
      if (k > 0) begin repeat (k) @(posedge clk); #1; end
    end
    @(negedge clk); rdy_mode = 0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
